// File: rtl/keypad_scan_entry_if.sv
// Keypad scan/entry bundle: clear input, keypad row/column lines and the accepted-key outputs.
`timescale 1ns/1ps
interface keypad_scan_entry_if;
  logic        clr;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry;

  // master: whatever drives the keypad/clear (board or bench); slave: the scanner
  modport master (output clr, col, input row, key_valid, key_code, entry);
  modport slave  (input clr, col, output row, key_valid, key_code, entry);
endinterface

// File: rtl/keypad_scan_entry.sv
// 4x4 matrix keypad scanner: walks an active-low row, debounces the synced columns,
// encodes one hex key per press and shifts accepted keys into a 4-digit entry register.
`timescale 1ns/1ps
module keypad_scan_entry #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 4
) (
  input  logic              mclk,
  input  logic              rst,
  keypad_scan_entry_if.slave kp
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N    = CW'(DEB_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

  logic [3:0]    col_s1_q, col_s2_q;
  logic [DW-1:0] div_q;
  logic          tick;
  state_t        state_q;
  logic [3:0]    row_q;
  logic [3:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          kv_q;
  logic [3:0]    code_q;
  logic [15:0]   entry_q;
  logic [1:0]    r_idx;
  logic [1:0]    c_idx;
  logic          pressed;
  logic [3:0]    code;
  logic [3:0]    row_next;

  // Two-flop synchroniser for the asynchronous column lines
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= kp.col;
      col_s2_q <= col_s1_q;
    end
  end

  // Scan-tick divider: free-running 0..SCAN_DIV-1
  always_ff @(posedge mclk or posedge rst) begin
    if (rst)        div_q <= '0;
    else if (tick)  div_q <= '0;
    else            div_q <= div_q + 1'b1;
  end

  assign tick = (div_q == DIV_LAST);

  // Decode the active row and the lowest low column into a key code
  always_comb begin
    r_idx = 2'd0;
    case (row_q)
      4'b1101: r_idx = 2'd1;
      4'b1011: r_idx = 2'd2;
      4'b0111: r_idx = 2'd3;
      default: r_idx = 2'd0;
    endcase
    c_idx = 2'd0;
    if      (!col_s2_q[0]) c_idx = 2'd0;
    else if (!col_s2_q[1]) c_idx = 2'd1;
    else if (!col_s2_q[2]) c_idx = 2'd2;
    else if (!col_s2_q[3]) c_idx = 2'd3;
  end

  assign pressed  = (col_s2_q != 4'hF);
  assign code     = {r_idx, c_idx};
  assign cnt_inc  = cnt_q + 1'b1;
  assign row_next = {row_q[2:0], row_q[3]};

  // Scan / debounce / release sequencer with the accepted-key and entry registers.
  // clr is applied last so it overrides a shift landing in the same cycle.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      row_q   <= 4'b1110;
      cand_q  <= 4'h0;
      cnt_q   <= '0;
      kv_q    <= 1'b0;
      code_q  <= 4'h0;
      entry_q <= 16'h0000;
    end else begin
      kv_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (!pressed) begin
              row_q <= row_next;
            end else begin
              cand_q <= code;
              if (DEB_N == CW'(1)) begin
                // single-tick debounce: accept on the detection tick
                kv_q    <= 1'b1;
                code_q  <= code;
                entry_q <= {entry_q[11:0], code};
                cnt_q   <= '0;
                state_q <= RELEASE;
              end else begin
                cnt_q   <= CW'(1);
                state_q <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (pressed && code == cand_q) begin
              if (cnt_inc == DEB_N) begin
                kv_q    <= 1'b1;
                code_q  <= cand_q;
                entry_q <= {entry_q[11:0], cand_q};
                cnt_q   <= '0;
                state_q <= RELEASE;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              // bounce or a different key: resume scanning from the next row
              cnt_q   <= '0;
              row_q   <= row_next;
              state_q <= SCAN;
            end
          end
          RELEASE: begin
            if (!pressed) begin
              if (cnt_inc == DEB_N) begin
                cnt_q   <= '0;
                row_q   <= row_next;
                state_q <= SCAN;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          default: begin
            state_q <= SCAN;
            cnt_q   <= '0;
          end
        endcase
      end
      if (kp.clr) entry_q <= 16'h0000;
    end
  end

  assign kp.row       = row_q;
  assign kp.key_valid = kv_q;
  assign kp.key_code  = code_q;
  assign kp.entry     = entry_q;
endmodule

// File: tb/tb_keypad_scan_entry.sv
// Bench for keypad_scan_entry: keypad model, pulse monitor and a key-list entry model.
`timescale 1ns/1ps
module tb_keypad_scan_entry;
  localparam int SD = 4;
  localparam int DT = 3;

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  always #5 mclk = ~mclk;

  keypad_scan_entry_if kp();
  keypad_scan_entry #(.SCAN_DIV(SD), .DEB_TICKS(DT)) dut (.mclk(mclk), .rst(rst), .kp(kp));

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] press_mask = 16'h0000;
  logic [15:0] exp_entry  = 16'h0000;

  // Keypad: a pressed key (bit = row*4+col) pulls its column low while its row is driven
  always_comb begin
    kp.col = 4'hF;
    for (int k = 0; k < 16; k++)
      if (press_mask[k] && kp.row[k/4] == 1'b0) kp.col[k%4] = 1'b0;
  end

  // Pulse monitor
  int         kv_cnt = 0;
  int         wide   = 0;
  logic       kv_prev = 1'b0;
  logic [3:0] kv_last = 4'h0;
  always @(negedge mclk) begin
    if (kp.key_valid === 1'b1) begin
      kv_cnt  <= kv_cnt + 1;
      kv_last <= kp.key_code;
      if (kv_prev) wide <= wide + 1;
    end
    kv_prev <= (kp.key_valid === 1'b1);
  end

  // Posedges since reset release, to locate scan ticks
  int cyc = 0;
  always @(posedge mclk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic step();
    @(negedge mclk);
    #1;
  endtask

  function automatic logic [15:0] shift_in(input logic [15:0] e, input logic [3:0] k);
    return 16'((int'(e) * 16 + int'(k)) % 65536);
  endfunction

  task automatic wait_kv(input int base, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      if (kv_cnt > base) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int r;
    logic [3:0] er;
    bit kv_seen;
    rst = 1'b1;
    kp.clr = 1'b0;
    repeat (3) step();
    n_cmp += 4;
    if (kp.row !== 4'b1110) begin n_bad++; $display("FAIL reset_row got %b want 1110", kp.row); end
    if (kp.key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_kv got %b want 0", kp.key_valid); end
    if (kp.key_code !== 4'h0) begin n_bad++; $display("FAIL reset_code got %h want 0", kp.key_code); end
    if (kp.entry !== 16'h0) begin n_bad++; $display("FAIL reset_entry got %h want 0000", kp.entry); end
    rst = 1'b0;
    kv_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      r  = (i / SD) % 4;
      er = ~(4'b0001 << r);
      n_cmp++;
      if (kp.row !== er) begin n_bad++; $display("FAIL idle_row cyc%0d got %b want %b", i, kp.row, er); end
      if (kp.key_valid !== 1'b0) kv_seen = 1'b1;
    end
    n_cmp += 2;
    if (kv_seen) begin n_bad++; $display("FAIL idle_kv got 1 want 0"); end
    if (kp.entry !== 16'h0) begin n_bad++; $display("FAIL idle_entry got %h want 0000", kp.entry); end
  endtask

  task automatic test_single_hold();
    int base, n;
    bit ok, held_ok;
    base = kv_cnt;
    press_mask = 16'h0200;
    wait_kv(base, 80, ok);
    exp_entry = shift_in(exp_entry, 4'h9);
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL hold_kv timeout got none want pulse"); end
    if (kv_last !== 4'h9) begin n_bad++; $display("FAIL hold_code got %h want 9", kv_last); end
    if (kp.entry !== exp_entry) begin n_bad++; $display("FAIL hold_entry got %h want %h", kp.entry, exp_entry); end
    held_ok = 1'b1;
    repeat (30) begin
      step();
      if (kp.row !== 4'b1011) held_ok = 1'b0;
    end
    n_cmp += 2;
    if (!held_ok) begin n_bad++; $display("FAIL hold_row not held got %b want 1011", kp.row); end
    if (kv_cnt !== base + 1) begin n_bad++; $display("FAIL hold_pulses got %0d want 1", kv_cnt - base); end
    press_mask = 16'h0000;
    n = 0;
    while (kp.row === 4'b1011 && n < 40) begin step(); n++; end
    n_cmp += 2;
    if (kp.row !== 4'b0111) begin n_bad++; $display("FAIL release_row got %b want 0111", kp.row); end
    if (n < 9 || n > 16) begin n_bad++; $display("FAIL release_time got %0d want 9..16", n); end
    repeat (20) step();
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap, input string tag);
    int base;
    base = kv_cnt;
    press_mask = 16'h0001 << k;
    repeat (hold) step();
    press_mask = 16'h0000;
    repeat (gap) step();
    exp_entry = shift_in(exp_entry, k);
    n_cmp += 3;
    if (kv_cnt !== base + 1) begin n_bad++; $display("FAIL %s_pulses got %0d want 1", tag, kv_cnt - base); end
    if (kv_last !== k) begin n_bad++; $display("FAIL %s_code got %h want %h", tag, kv_last, k); end
    if (kp.entry !== exp_entry) begin n_bad++; $display("FAIL %s_entry got %h want %h", tag, kp.entry, exp_entry); end
  endtask

  task automatic test_sequence();
    for (int k = 1; k <= 5; k++) begin
      press(4'(k), 60, 40, "seq");
      if (k == 4) begin
        n_cmp++;
        if (kp.entry !== 16'h1234) begin n_bad++; $display("FAIL seq4_entry got %h want 1234", kp.entry); end
      end
    end
    n_cmp++;
    if (kp.entry !== 16'h2345) begin n_bad++; $display("FAIL seq5_entry got %h want 2345", kp.entry); end
  endtask

  task automatic test_bounce();
    int base;
    base = kv_cnt;
    while (cyc % SD != 2) step();
    repeat (12) begin
      press_mask = 16'h0080;
      repeat (SD) step();
      press_mask = 16'h0000;
      repeat (SD) step();
    end
    n_cmp++;
    if (kv_cnt !== base) begin n_bad++; $display("FAIL bounce_kv got %0d pulses want 0", kv_cnt - base); end
    press(4'h7, 60, 40, "bounce_clean");
  endtask

  task automatic test_clr_accept();
    int base;
    bit det;
    logic [3:0] prev;
    base = kv_cnt;
    press_mask = 16'h0005;
    det  = 1'b0;
    prev = kp.row;
    for (int i = 0; i < 60 && !det; i++) begin
      step();
      if (cyc % SD == 0 && kp.row === 4'b1110 && prev === 4'b1110) det = 1'b1;
      prev = kp.row;
    end
    n_cmp++;
    if (!det) begin n_bad++; $display("FAIL clr_detect timeout got none want detect"); end
    repeat ((DT - 1) * SD - 1) step();
    kp.clr = 1'b1;
    step();
    kp.clr = 1'b0;
    exp_entry = 16'h0000;
    n_cmp += 3;
    if (kp.key_valid !== 1'b1) begin n_bad++; $display("FAIL clr_kv got %b want 1", kp.key_valid); end
    if (kp.key_code !== 4'h0) begin n_bad++; $display("FAIL clr_code got %h want 0", kp.key_code); end
    if (kp.entry !== 16'h0000) begin n_bad++; $display("FAIL clr_entry got %h want 0000", kp.entry); end
    repeat (20) step();
    press_mask = 16'h0000;
    repeat (40) step();
    n_cmp++;
    if (kv_cnt !== base + 1) begin n_bad++; $display("FAIL clr_pulses got %0d want 1", kv_cnt - base); end
  endtask

  task automatic test_reset_release();
    int base;
    bit ok;
    logic [3:0] k;
    k = 4'($urandom_range(0, 15));
    base = kv_cnt;
    press_mask = 16'h0001 << k;
    wait_kv(base, 80, ok);
    repeat (5) step();
    rst = 1'b1;
    #1;
    exp_entry = 16'h0000;
    n_cmp += 5;
    if (!ok) begin n_bad++; $display("FAIL rr_first timeout got none want pulse"); end
    if (kp.row !== 4'b1110) begin n_bad++; $display("FAIL rr_row got %b want 1110", kp.row); end
    if (kp.key_valid !== 1'b0) begin n_bad++; $display("FAIL rr_kv got %b want 0", kp.key_valid); end
    if (kp.key_code !== 4'h0) begin n_bad++; $display("FAIL rr_code got %h want 0", kp.key_code); end
    if (kp.entry !== 16'h0) begin n_bad++; $display("FAIL rr_entry got %h want 0000", kp.entry); end
    step();
    rst = 1'b0;
    base = kv_cnt;
    repeat (70) step();
    press_mask = 16'h0000;
    repeat (40) step();
    exp_entry = shift_in(exp_entry, k);
    n_cmp += 3;
    if (kv_cnt !== base + 1) begin n_bad++; $display("FAIL rr_pulses got %0d want 1", kv_cnt - base); end
    if (kv_last !== k) begin n_bad++; $display("FAIL rr_code2 got %h want %h", kv_last, k); end
    if (kp.entry !== exp_entry) begin n_bad++; $display("FAIL rr_entry2 got %h want %h", kp.entry, exp_entry); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      press(4'($urandom_range(0, 15)), int'($urandom_range(50, 80)), int'($urandom_range(35, 60)), "rand");
  endtask

  task automatic test_pulse_width();
    n_cmp++;
    if (wide !== 0) begin n_bad++; $display("FAIL pulse_width got %0d long pulses want 0", wide); end
  endtask

  initial begin
    kp.clr = 1'b0;
    test_reset();
    test_single_hold();
    test_sequence();
    test_bounce();
    test_clr_accept();
    test_reset_release();
    test_random();
    test_pulse_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
